// File: rtl/mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// mult_seq_pkg
// Shared constants for the sequential digit-serial multiplier controller:
// FSM state encodings and helpers that derive the digit count and the
// digit-index width from the operand width.
// -----------------------------------------------------------------------------
package mult_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of 2-bit digits in an n-bit operand.
  function automatic int digit_count(input int n);
    return n / 2;
  endfunction

  // Width of a digit index; kept at least 1 bit so K=2 still has a counter.
  function automatic int idx_width(input int n);
    return (n / 2 <= 2) ? 1 : $clog2(n / 2);
  endfunction

endpackage

// File: rtl/mult2x2.sv
// -----------------------------------------------------------------------------
// mult2x2
// Purely combinational 2-bit x 2-bit unsigned multiplier. This is the single
// shared arithmetic core that the sequential controller time-multiplexes.
// Ports:
//   i_a  [1:0]  multiplicand digit
//   i_b  [1:0]  multiplier digit
//   o_p  [3:0]  product i_a * i_b
// -----------------------------------------------------------------------------
module mult2x2 (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_p
);

  assign o_p = i_a * i_b;

endmodule

// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
// Sequential N x N unsigned multiplier. Operands are split into 2-bit digits;
// one digit pair per cycle goes through the shared mult2x2 core and the
// shifted partial product is accumulated at 2N bits.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one partial product per cycle, K*K cycles
// DONE  | product held, out_valid high until out_ready
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   in_valid   operand pair presented        in_ready   accepting (IDLE)
//   a, b [N]   unsigned operands
//   out_valid  product valid (DONE)          out_ready  consumer accepts
//   product    [2N] result a*b               busy       CALC or DONE
// -----------------------------------------------------------------------------
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int K  = digit_count(N);
  localparam int IW = idx_width(N);
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  logic [1:0]     r_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] r_prod;
  logic [IW-1:0]  r_i;
  logic [IW-1:0]  r_j;

  logic [N-1:0]   w_a_sh;
  logic [N-1:0]   w_b_sh;
  logic [3:0]     w_pp;
  logic [IW:0]    w_dsum;
  logic [2*N-1:0] w_pp_ext;
  logic [2*N-1:0] w_pp_sh;
  logic [2*N-1:0] w_acc_nxt;
  logic           w_last;

  // Digit selection by shifting the operand down 2*index bits.
  assign w_a_sh = r_a >> {r_i, 1'b0};
  assign w_b_sh = r_b >> {r_j, 1'b0};

  mult2x2 u_core (
    .i_a (w_a_sh[1:0]),
    .i_b (w_b_sh[1:0]),
    .o_p (w_pp)
  );

  // i+j can reach 2K-2, one bit wider than a single index.
  assign w_dsum    = {1'b0, r_i} + {1'b0, r_j};
  assign w_pp_ext  = {{(2*N-4){1'b0}}, w_pp};
  assign w_pp_sh   = w_pp_ext << {w_dsum, 1'b0};
  assign w_acc_nxt = r_acc + w_pp_sh;
  assign w_last    = (r_i == LAST) && (r_j == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_prod  <= '0;
      r_i     <= '0;
      r_j     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_nxt;
          if (w_last) begin
            r_prod  <= w_acc_nxt;
            r_state <= ST_DONE;
          end else if (r_j == LAST) begin
            r_j <= '0;
            r_i <= r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_CALC) || (r_state == ST_DONE);
  assign product   = r_prod;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_ctrl
// Drives an N=4 and an N=8 instance. A cycle-level behavioural model tracks,
// for each instance, whether an operation is in flight, how many cycles have
// elapsed since acceptance and the arithmetic product a*b; every negedge the
// DUT outputs are compared against it. Directed operations pin the model with
// literal products and latencies, then a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [2];
  logic        out_ready [2];
  logic [7:0]  a [2];
  logic [7:0]  b [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        busy      [2];
  logic [7:0]  p4;
  logic [15:0] p8;
  logic [15:0] prod_w [2];

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;
  bit started = 1'b0;

  // model state
  bit          m_pend [2];
  bit          m_outv [2];
  int          m_cnt  [2];
  logic [15:0] m_exp  [2];
  logic [15:0] m_prod [2];
  int          kk     [2];

  always #5 clk = ~clk;

  mult_seq_ctrl #(.N(4)) u_n4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .a         (a[0][3:0]),
    .b         (b[0][3:0]),
    .out_valid (out_valid[0]),
    .out_ready (out_ready[0]),
    .product   (p4),
    .busy      (busy[0])
  );

  mult_seq_ctrl #(.N(8)) u_n8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .a         (a[1]),
    .b         (b[1]),
    .out_valid (out_valid[1]),
    .out_ready (out_ready[1]),
    .product   (p8),
    .busy      (busy[1])
  );

  assign prod_w[0] = {8'h00, p4};
  assign prod_w[1] = p8;

  task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (N=%0d) t=%0t: got %0d expected %0d", nm, (u == 0) ? 4 : 8, $time, act, exp);
    end
  endtask

  // Behavioural model: an accepted operation yields a*b after K*K compute
  // cycles and stays presented until the consumer takes it.
  always @(posedge clk) begin
    logic [15:0] av, bv;
    edge_cnt++;
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_pend[u] = 1'b0;
        m_outv[u] = 1'b0;
        m_cnt[u]  = 0;
        m_prod[u] = 16'd0;
        started   = 1'b1;
      end else if (m_outv[u]) begin
        if (out_ready[u]) begin
          m_outv[u] = 1'b0;
          m_pend[u] = 1'b0;
        end
      end else if (m_pend[u]) begin
        m_cnt[u]++;
        if (m_cnt[u] == kk[u]) begin
          m_outv[u] = 1'b1;
          m_prod[u] = m_exp[u];
        end
      end else if (in_valid[u]) begin
        av = (u == 0) ? {12'd0, a[u][3:0]} : {8'd0, a[u]};
        bv = (u == 0) ? {12'd0, b[u][3:0]} : {8'd0, b[u]};
        m_pend[u] = 1'b1;
        m_cnt[u]  = 0;
        m_exp[u]  = av * bv;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int u = 0; u < 2; u++) begin
        chk("in_ready",  u, {31'd0, in_ready[u]},  {31'd0, !m_pend[u]});
        chk("out_valid", u, {31'd0, out_valid[u]}, {31'd0, m_outv[u]});
        chk("busy",      u, {31'd0, busy[u]},      {31'd0, m_pend[u]});
        chk("product",   u, {16'd0, prod_w[u]},    {16'd0, m_prod[u]});
      end
    end
  end

  // Latency is counted as rising edges from the accept edge to the first edge
  // at which the consumer samples out_valid high.
  task automatic do_op(input int u, input int av, input int bv, input int hold,
                       input bit intrude, input int exp_p, input int exp_lat);
    int e0;
    int n;
    int lat;
    n = 0;
    @(negedge clk);
    while (!in_ready[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", u, {31'd0, in_ready[u]}, 32'd1);
    in_valid[u] = 1'b1;
    a[u] = 8'(av);
    b[u] = 8'(bv);
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
    e0 = edge_cnt;
    if (intrude) begin
      @(posedge clk);
      @(posedge clk);
      #1;
      in_valid[u] = 1'b1;
      a[u] = 8'd7;
      b[u] = 8'd7;
      @(negedge clk);
      chk("in_ready_busy", u, {31'd0, in_ready[u]}, 32'd0);
    end
    n = 0;
    @(negedge clk);
    while (!out_valid[u] && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_wait", u, {31'd0, out_valid[u]}, 32'd1);
    in_valid[u] = 1'b0;
    lat = edge_cnt + 1 - e0;
    chk("latency", u, 32'(lat), 32'(exp_lat));
    chk("product_lit", u, {16'd0, prod_w[u]}, 32'(exp_p));
    repeat (hold) @(negedge clk);
    if (hold > 0) begin
      chk("product_hold", u, {16'd0, prod_w[u]}, 32'(exp_p));
      chk("out_valid_hold", u, {31'd0, out_valid[u]}, 32'd1);
    end
    out_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[u] = 1'b0;
    @(negedge clk);
    chk("in_ready_after", u, {31'd0, in_ready[u]}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    kk[0] = 4;
    kk[1] = 16;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b0;
      a[u] = 8'd0;
      b[u] = 8'd0;
      m_pend[u] = 1'b0;
      m_outv[u] = 1'b0;
      m_cnt[u]  = 0;
      m_exp[u]  = 16'd0;
      m_prod[u] = 16'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_in_ready",  u, {31'd0, in_ready[u]},  32'd1);
      chk("rst_out_valid", u, {31'd0, out_valid[u]}, 32'd0);
      chk("rst_busy",      u, {31'd0, busy[u]},      32'd0);
      chk("rst_product",   u, {16'd0, prod_w[u]},    32'd0);
    end

    do_op(0, 2, 3, 0, 1'b0, 6, 5);
    do_op(0, 15, 15, 0, 1'b0, 225, 5);
    do_op(0, 0, 9, 0, 1'b0, 0, 5);
    do_op(0, 13, 11, 3, 1'b0, 143, 5);
    do_op(0, 5, 6, 0, 1'b1, 30, 5);

    // reset during the third compute cycle
    @(negedge clk);
    in_valid[0] = 1'b1;
    a[0] = 8'd9;
    b[0] = 8'd9;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready",  0, {31'd0, in_ready[0]},  32'd1);
    chk("midrst_out_valid", 0, {31'd0, out_valid[0]}, 32'd0);
    chk("midrst_product",   0, {16'd0, prod_w[0]},    32'd0);
    chk("midrst_busy",      0, {31'd0, busy[0]},      32'd0);
    do_op(0, 3, 3, 0, 1'b0, 9, 5);

    do_op(1, 255, 255, 0, 1'b0, 65025, 17);
    do_op(1, 200, 3, 2, 1'b0, 600, 17);

    // randomized traffic with occasional resets
    repeat (3000) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 199) != 0);
      for (int u = 0; u < 2; u++) begin
        in_valid[u]  = 1'($urandom_range(0, 1));
        a[u]         = 8'($urandom);
        b[u]         = 8'($urandom);
        out_ready[u] = ($urandom_range(0, 3) != 0);
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u]  = 1'b0;
      out_ready[u] = 1'b1;
    end
    repeat (30) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
